// File: rtl/sevenseg_pkg.sv
// Shared 7-segment definitions: glyph patterns (a..g = bits 6..0, 1 = lit),
// BCD codes for the special glyphs and small helpers used by encoder and decoder.
package sevenseg_pkg;

  localparam int unsigned SEG_W      = 7;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned MAX_DIGITS = 8;

  localparam logic [SEG_W-1:0] SEG_0   = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_1   = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_2   = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_3   = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_4   = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_5   = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_6   = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG_7   = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG_8   = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9   = 7'b1111011;
  localparam logic [SEG_W-1:0] SEG_OVF = 7'b1110111;

  localparam logic [BCD_W-1:0] BCD_OVF = 4'hA;
  localparam logic [BCD_W-1:0] BCD_INV = 4'hF;

  // Decoded view of one segment pattern.
  typedef struct packed {
    logic [BCD_W-1:0] bcd;
    logic             ovf;
    logic             inv;
  } seg_dec_t;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [MAX_DIGITS-1:0] v);
    return (v != '0) && ((v & (v - MAX_DIGITS'(1))) == '0);
  endfunction

endpackage

// File: rtl/sevenseg_pattern_decode.sv
// Combinational segment-pattern to BCD decoder; unknown patterns (blank included)
// map to BCD_INV with inv set, the over-range glyph to BCD_OVF with ovf set.
module sevenseg_pattern_decode
  import sevenseg_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output seg_dec_t         dec_c
);

  always_comb begin
    dec_c = '{bcd: BCD_INV, ovf: 1'b0, inv: 1'b1};
    case (seg)
      SEG_0:   dec_c = '{bcd: 4'd0, ovf: 1'b0, inv: 1'b0};
      SEG_1:   dec_c = '{bcd: 4'd1, ovf: 1'b0, inv: 1'b0};
      SEG_2:   dec_c = '{bcd: 4'd2, ovf: 1'b0, inv: 1'b0};
      SEG_3:   dec_c = '{bcd: 4'd3, ovf: 1'b0, inv: 1'b0};
      SEG_4:   dec_c = '{bcd: 4'd4, ovf: 1'b0, inv: 1'b0};
      SEG_5:   dec_c = '{bcd: 4'd5, ovf: 1'b0, inv: 1'b0};
      SEG_6:   dec_c = '{bcd: 4'd6, ovf: 1'b0, inv: 1'b0};
      SEG_7:   dec_c = '{bcd: 4'd7, ovf: 1'b0, inv: 1'b0};
      SEG_8:   dec_c = '{bcd: 4'd8, ovf: 1'b0, inv: 1'b0};
      SEG_9:   dec_c = '{bcd: 4'd9, ovf: 1'b0, inv: 1'b0};
      SEG_OVF: dec_c = '{bcd: BCD_OVF, ovf: 1'b1, inv: 1'b0};
      default: ;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Snoops a multiplexed common-cathode 7-segment bus, captures each digit once it has
// been stable long enough, and presents one BCD word per full scan on valid/ready.
module sevenseg_scan_decoder
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SEG_W-1:0]            seg_in,
  input  logic [NUM_DIGITS-1:0]       dig_sel,
  output logic                        frame_valid,
  input  logic                        frame_ready,
  output logic [BCD_W*NUM_DIGITS-1:0] frame_bcd,
  output logic [NUM_DIGITS-1:0]       frame_ovf,
  output logic [NUM_DIGITS-1:0]       frame_inv,
  output logic                        frame_drop
);

  localparam int unsigned      BUS_W   = BCD_W * NUM_DIGITS;
  localparam int unsigned      RUN_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
  localparam logic [RUN_W-1:0] RUN_CAP = RUN_W'(STABLE_CYCLES - 1);

  logic [SEG_W-1:0]      seg_m, s_seg, p_seg;
  logic [NUM_DIGITS-1:0] dig_m, s_dig, p_dig;
  logic [RUN_W-1:0]      run;
  logic                  done;

  logic [BUS_W-1:0]      dig_bcd;
  logic [NUM_DIGITS-1:0] dig_ovf, dig_inv, mask;

  logic                  comp_pend;
  logic [BUS_W-1:0]      comp_bcd;
  logic [NUM_DIGITS-1:0] comp_ovf, comp_inv;

  seg_dec_t              dec_c;
  logic                  same_c, capture_c, complete_c;
  logic [NUM_DIGITS-1:0] mask_next_c, ovf_next_c, inv_next_c;
  logic [BUS_W-1:0]      bcd_next_c;

  sevenseg_pattern_decode u_decode (
    .seg   (s_seg),
    .dec_c (dec_c)
  );

  // Capture decision and the digit set as it would look after this edge's capture.
  always_comb begin
    same_c      = (s_seg == p_seg) && (s_dig == p_dig);
    capture_c   = same_c && (run == RUN_CAP) && !done && is_onehot(MAX_DIGITS'(s_dig));
    mask_next_c = mask | s_dig;
    complete_c  = capture_c && (mask_next_c == '1);
    bcd_next_c  = dig_bcd;
    ovf_next_c  = dig_ovf;
    inv_next_c  = dig_inv;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (s_dig[i]) begin
        bcd_next_c[BCD_W*i +: BCD_W] = dec_c.bcd;
        ovf_next_c[i]                = dec_c.ovf;
        inv_next_c[i]                = dec_c.inv;
      end
    end
  end

  // Two-flop synchronisers plus the dwell-length tracker.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_m <= '0;
      s_seg <= '0;
      p_seg <= '0;
      dig_m <= '0;
      s_dig <= '0;
      p_dig <= '0;
      run   <= '0;
      done  <= 1'b0;
    end else begin
      seg_m <= seg_in;
      s_seg <= seg_m;
      p_seg <= s_seg;
      dig_m <= dig_sel;
      s_dig <= dig_m;
      p_dig <= s_dig;
      if (!same_c) begin
        run  <= RUN_W'(1);
        done <= 1'b0;
      end else begin
        if (run != RUN_MAX) run <= run + RUN_W'(1);
        if (capture_c) done <= 1'b1;
      end
    end
  end

  // Per-digit registers, coverage mask and the completed-frame staging register.
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_bcd   <= '0;
      dig_ovf   <= '0;
      dig_inv   <= '0;
      mask      <= '0;
      comp_pend <= 1'b0;
      comp_bcd  <= '0;
      comp_ovf  <= '0;
      comp_inv  <= '0;
    end else begin
      comp_pend <= complete_c;
      if (capture_c) begin
        dig_bcd <= bcd_next_c;
        dig_ovf <= ovf_next_c;
        dig_inv <= inv_next_c;
        mask    <= complete_c ? '0 : mask_next_c;
      end
      if (complete_c) begin
        comp_bcd <= bcd_next_c;
        comp_ovf <= ovf_next_c;
        comp_inv <= inv_next_c;
      end
    end
  end

  // Output frame register with valid/ready; a frame arriving while one is held is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_valid <= 1'b0;
      frame_bcd   <= '0;
      frame_ovf   <= '0;
      frame_inv   <= '0;
      frame_drop  <= 1'b0;
    end else begin
      frame_drop <= 1'b0;
      if (comp_pend) begin
        if (!frame_valid || frame_ready) begin
          frame_valid <= 1'b1;
          frame_bcd   <= comp_bcd;
          frame_ovf   <= comp_ovf;
          frame_inv   <= comp_inv;
        end else begin
          frame_drop <= 1'b1;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Directed bench for sevenseg_scan_decoder (4 digits, 4-cycle stability window).
module tb_sevenseg_scan_decoder;

  localparam int unsigned ND = 4;
  localparam int unsigned SC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    seg_in;
  logic [ND-1:0] dig_sel;
  logic          frame_valid;
  logic          frame_ready;
  logic [15:0]   frame_bcd;
  logic [ND-1:0] frame_ovf;
  logic [ND-1:0] frame_inv;
  logic          frame_drop;

  always #5 clk = ~clk;

  sevenseg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_bcd   (frame_bcd),
    .frame_ovf   (frame_ovf),
    .frame_inv   (frame_inv),
    .frame_drop  (frame_drop)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          hs_cnt, drop_cnt, hold_bad;
  logic [15:0] last_bcd, hold_exp;
  logic [3:0]  last_ovf, last_inv;

  typedef struct {
    logic [27:0] pats;
    int          dwell;
    int          exp_frames;
    logic [15:0] exp_bcd;
    logic [3:0]  exp_ovf;
    logic [3:0]  exp_inv;
  } vec_t;

  vec_t vecs[5];

  // Reference encoder: BCD to common-cathode glyph, 10..15 shown as over-range.
  function automatic logic [6:0] enc(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b1110111;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: note a handshake that this edge completes, then observe the outputs after it.
  task automatic tick();
    if (frame_valid && frame_ready) begin
      hs_cnt++;
      last_bcd = frame_bcd;
      last_ovf = frame_ovf;
      last_inv = frame_inv;
    end
    @(posedge clk);
    #1;
    if (frame_drop) drop_cnt++;
    if (frame_valid && !frame_ready && frame_bcd !== hold_exp) hold_bad++;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic idle(input int n);
    seg_in  = 7'd0;
    dig_sel = '0;
    ticks(n);
  endtask

  task automatic do_reset();
    seg_in  = 7'd0;
    dig_sel = '0;
    rst     = 1'b1;
    tick();
    rst = 1'b0;
    ticks(3);
    hs_cnt   = 0;
    drop_cnt = 0;
    hold_bad = 0;
    last_bcd = '0;
    last_ovf = '0;
    last_inv = '0;
  endtask

  // Show the selected digits in ascending order, pattern for digit i at pats[7i+6:7i].
  task automatic scan(input logic [27:0] pats, input logic [3:0] which, input int dwell);
    for (int i = 0; i < 4; i++) begin
      if (which[i]) begin
        seg_in  = pats[7*i +: 7];
        dig_sel = 4'b0001 << i;
        ticks(dwell);
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    seg_in      = '0;
    dig_sel     = '0;
    frame_ready = 1'b1;
    hold_exp    = '0;
    hs_cnt      = 0;
    drop_cnt    = 0;
    hold_bad    = 0;
    last_bcd    = '0;
    last_ovf    = '0;
    last_inv    = '0;

    vecs[0] = '{{enc(4), enc(3), enc(2), enc(1)}, 8, 1, 16'h4321, 4'b0000, 4'b0000};
    vecs[1] = '{{enc(2), 7'b1110111, 7'b0000000, enc(1)}, 8, 1, 16'h2AF1, 4'b0100, 4'b0010};
    vecs[2] = '{{enc(4), enc(3), enc(2), enc(1)}, 3, 0, 16'h0000, 4'b0000, 4'b0000};
    vecs[3] = '{{enc(0), enc(7), enc(8), enc(9)}, 4, 1, 16'h0789, 4'b0000, 4'b0000};
    vecs[4] = '{{enc(9), enc(0), enc(6), enc(5)}, 5, 1, 16'h9065, 4'b0000, 4'b0000};

    // Table of single scans with ready held high.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      frame_ready = 1'b1;
      scan(vecs[v].pats, 4'hF, vecs[v].dwell);
      idle(12);
      check($sformatf("vec%0d_frames", v), 32'(hs_cnt), 32'(vecs[v].exp_frames));
      check($sformatf("vec%0d_bcd", v), 32'(last_bcd), 32'(vecs[v].exp_bcd));
      check($sformatf("vec%0d_ovf", v), 32'(last_ovf), 32'(vecs[v].exp_ovf));
      check($sformatf("vec%0d_inv", v), 32'(last_inv), 32'(vecs[v].exp_inv));
    end

    // Multi-hot and all-zero selects never capture; recapture overwrites.
    do_reset();
    frame_ready = 1'b1;
    scan({enc(4), 7'd0, 7'd0, enc(1)}, 4'b1001, 6);
    seg_in  = enc(7);
    dig_sel = 4'b0110;
    ticks(10);
    dig_sel = 4'b0000;
    ticks(10);
    scan({enc(6), 7'd0, 7'd0, enc(5)}, 4'b1001, 6);
    idle(12);
    check("mhot_no_frame", 32'(hs_cnt), 32'd0);
    scan({7'd0, enc(3), enc(2), 7'd0}, 4'b0110, 6);
    idle(12);
    check("mhot_frames", 32'(hs_cnt), 32'd1);
    check("mhot_bcd", 32'(last_bcd), 32'h6325);

    // Backpressure: first frame held, second completion dropped with a one-cycle pulse.
    do_reset();
    frame_ready = 1'b0;
    hold_exp    = 16'h4321;
    scan({enc(4), enc(3), enc(2), enc(1)}, 4'hF, 6);
    idle(12);
    check("bp_first", {15'd0, frame_valid, frame_bcd}, {15'd0, 1'b1, 16'h4321});
    scan({enc(8), enc(7), enc(6), enc(5)}, 4'hF, 6);
    idle(12);
    check("bp_drop_cycles", 32'(drop_cnt), 32'd1);
    check("bp_held_stable", 32'(hold_bad), 32'd0);
    check("bp_held_bcd", 32'(frame_bcd), 32'h4321);
    frame_ready = 1'b1;
    ticks(4);
    check("bp_handshakes", 32'(hs_cnt), 32'd1);
    check("bp_accepted", 32'(last_bcd), 32'h4321);
    check("bp_valid_low", 32'(frame_valid), 32'd0);

    // Reset with a frame held and two digits captured discards everything.
    do_reset();
    frame_ready = 1'b0;
    scan({enc(4), enc(3), enc(2), enc(1)}, 4'hF, 6);
    idle(12);
    scan({7'd0, 7'd0, enc(2), enc(1)}, 4'b0011, 6);
    seg_in  = 7'd0;
    dig_sel = '0;
    rst     = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_outputs", {8'd0, frame_valid, frame_drop, frame_ovf, frame_inv, frame_bcd}, 32'd0);
    frame_ready = 1'b1;
    hs_cnt      = 0;
    idle(4);
    scan({enc(4), enc(3), 7'd0, 7'd0}, 4'b1100, 6);
    idle(12);
    check("rst_partial", 32'(hs_cnt), 32'd0);
    scan({7'd0, 7'd0, enc(8), enc(7)}, 4'b0011, 6);
    idle(12);
    check("rst_frames", 32'(hs_cnt), 32'd1);
    check("rst_bcd", 32'(last_bcd), 32'h4387);

    // Loop-back through the reference encoder for every BCD input.
    do_reset();
    frame_ready = 1'b1;
    for (int v = 0; v < 16; v++) begin
      logic [3:0]  d;
      logic [23:0] exp_word;
      d      = 4'(v);
      hs_cnt = 0;
      scan({enc(d), enc(d), enc(d), enc(d)}, 4'hF, 6);
      idle(12);
      exp_word = (v < 10) ? {d, d, d, d, 4'h0, 4'h0} : {16'hAAAA, 4'hF, 4'h0};
      check($sformatf("loop%0d_frames", v), 32'(hs_cnt), 32'd1);
      check($sformatf("loop%0d_word", v), {8'd0, last_bcd, last_ovf, last_inv}, {8'd0, exp_word});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
